// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, digit limits and load sanitiser for the BCD counter
package bcd_pkg;
   typedef logic [3:0] bcd_digit_t;
   localparam bcd_digit_t BCD_MAX = 4'd9;
   localparam bcd_digit_t BCD_MIN = 4'd0;
   function automatic bcd_digit_t bcd_sanitise(input bcd_digit_t d);
      return (d > BCD_MAX) ? BCD_MIN : d;
   endfunction
endpackage

// File: rtl/bcd_digit_cell.sv
// bcd_digit_cell: one BCD digit register; steps up/down with 9<->0 roll, loads a sanitised nibble
module bcd_digit_cell
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   input  logic       up,
   input  logic       ld,
   input  bcd_digit_t ld_val,
   output bcd_digit_t q,
   output logic       at_max,
   output logic       at_min
);
   bcd_digit_t q_q, q_d;
   assign at_max = (q_q == BCD_MAX);
   assign at_min = (q_q == BCD_MIN);
   assign q      = q_q;
   always_comb begin
      q_d = ld    ? bcd_sanitise(ld_val) :
            !step ? q_q :
            up    ? (at_max ? BCD_MIN : q_q + 4'd1) :
                    (at_min ? BCD_MAX : q_q - 4'd1);
   end
   always_ff @(posedge clk) begin
      if (rst) q_q <= BCD_MIN;
      else     q_q <= q_d;
   end
endmodule

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: N-digit BCD up/down counter with wrap or saturate, tc and sticky wrapped flag.
// Define BCD_CNT_LOAD_EN to add the load/load_val parallel-load ports.
module bcd_updown_counter
   import bcd_pkg::*;
#(
   parameter int DIGITS  = 4,
   parameter bit WRAP_EN = 1'b1
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                up,
   input  logic                clr_wrap,
`ifdef BCD_CNT_LOAD_EN
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
`endif
   output logic [4*DIGITS-1:0] count,
   output logic                tc,
   output logic                wrapped
);
   logic [DIGITS-1:0]   at_max, at_min, lim, step;
   logic [4*DIGITS-1:0] ld_val;
   logic                ld, lim_all, en_eff, wrapped_q, wrapped_d;
`ifdef BCD_CNT_LOAD_EN
   assign ld     = load;
   assign ld_val = load_val;
`else
   assign ld     = 1'b0;
   assign ld_val = '0;
`endif
   assign lim     = up ? at_max : at_min;
   assign lim_all = &lim;
   assign tc      = en & lim_all;
   // In saturate mode a step at the limit is swallowed entirely, so no digit moves.
   assign en_eff  = en & ~ld & (WRAP_EN | ~lim_all);
   always_comb begin
      wrapped_d = (tc & ~ld) ? 1'b1 : clr_wrap ? 1'b0 : wrapped_q;
   end
   always_ff @(posedge clk) begin
      if (rst) wrapped_q <= 1'b0;
      else     wrapped_q <= wrapped_d;
   end
   assign wrapped = wrapped_q;
   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      if (g == 0) begin : g_lsd
         assign step[g] = en_eff;
      end else begin : g_ripple
         assign step[g] = en_eff & (&lim[g-1:0]);
      end
      bcd_digit_cell u_cell (
         .clk    (clk),
         .rst    (rst),
         .step   (step[g]),
         .up     (up),
         .ld     (ld),
         .ld_val (ld_val[4*g +: 4]),
         .q      (count[4*g +: 4]),
         .at_max (at_max[g]),
         .at_min (at_min[g])
      );
   end
endmodule
